// File: rtl/approx_dot_accumulator.sv
// Accumulates VEC_LEN signed products into one saturating or wrapping dot-product result.
// Latency: the result is valid on the edge that accepts the last product of a vector.
// Backpressure: while a result is held, prod_ready is low until res_ready drains it, leaving a one-cycle bubble.
module approx_dot_accumulator #(
    parameter int PROD_W  = 32,
    parameter int ACC_W   = 40,
    parameter int VEC_LEN = 16,
    parameter int SAT_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    output logic              prod_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              busy
);

    localparam int CNT_W = $clog2(VEC_LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               res_valid_q, res_valid_d;
    logic [ACC_W-1:0]   res_data_q, res_data_d;
    logic               res_ovf_q, res_ovf_d;

    logic               accept;
    logic [ACC_W-1:0]   prod_sext;
    logic [ACC_W:0]     sum_wide;
    logic               add_ovf;
    logic [ACC_W-1:0]   sum_next;
    logic               last_prod;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Ready depends only on registered state, so there is no path from res_ready.
    assign prod_ready = (state_q != HOLD);
    assign accept     = prod_valid & prod_ready;
    assign busy       = (state_q == ACC);
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_ovf    = res_ovf_q;
    assign last_prod  = (cnt_q == CNT_W'(VEC_LEN - 1));

    // Add one bit of headroom; overflow shows as disagreement of the two top sum bits.
    always_comb begin
        prod_sext = {{(ACC_W-PROD_W){prod_data[PROD_W-1]}}, prod_data};
        sum_wide  = {acc_q[ACC_W-1], acc_q} + {prod_sext[ACC_W-1], prod_sext};
        add_ovf   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        sum_next  = sum_wide[ACC_W-1:0];
        if (add_ovf && (SAT_EN != 0)) begin
            sum_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Next-state and datapath updates; flush outranks every other event.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_ovf_d   = res_ovf_q;
        if (flush) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        acc_d = prod_sext;
                        cnt_d = CNT_W'(1);
                        ovf_d = 1'b0;
                        if (VEC_LEN == 1) begin
                            state_d     = HOLD;
                            res_valid_d = 1'b1;
                            res_data_d  = prod_sext;
                            res_ovf_d   = 1'b0;
                        end else begin
                            state_d = ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc_d = sum_next;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | add_ovf;
                        if (last_prod) begin
                            state_d     = HOLD;
                            res_valid_d = 1'b1;
                            res_data_d  = sum_next;
                            res_ovf_d   = ovf_q | add_ovf;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        state_d     = IDLE;
                        res_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

endmodule

// File: tb/tb_approx_dot_accumulator.sv
// Directed bench for approx_dot_accumulator across four parameter sets sharing one input bus.
module tb_approx_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        prod_valid;
    logic [31:0] prod_data;
    logic        res_ready;

    // dut4: VEC_LEN=4, ACC_W=40 saturating
    logic        pr4, rv4, ovf4, busy4;
    logic [39:0] rd4;
    // dsat / dwrap: ACC_W=34, VEC_LEN=16
    logic        prs, rvs, ovfs, busys;
    logic [33:0] rds;
    logic        prw, rvw, ovfw, busyw;
    logic [33:0] rdw;
    // dut1: VEC_LEN=1
    logic        pr1, rv1, ovf1, busy1;
    logic [39:0] rd1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    approx_dot_accumulator #(.PROD_W(32), .ACC_W(40), .VEC_LEN(4), .SAT_EN(1)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(pr4), .res_valid(rv4), .res_ready(res_ready), .res_data(rd4),
        .res_ovf(ovf4), .busy(busy4));

    approx_dot_accumulator #(.PROD_W(32), .ACC_W(34), .VEC_LEN(16), .SAT_EN(1)) dsat (
        .clk(clk), .rst(rst), .flush(flush), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(prs), .res_valid(rvs), .res_ready(res_ready), .res_data(rds),
        .res_ovf(ovfs), .busy(busys));

    approx_dot_accumulator #(.PROD_W(32), .ACC_W(34), .VEC_LEN(16), .SAT_EN(0)) dwrap (
        .clk(clk), .rst(rst), .flush(flush), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(prw), .res_valid(rvw), .res_ready(res_ready), .res_data(rdw),
        .res_ovf(ovfw), .busy(busyw));

    approx_dot_accumulator #(.PROD_W(32), .ACC_W(40), .VEC_LEN(1), .SAT_EN(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_ready(pr1), .res_valid(rv1), .res_ready(res_ready), .res_data(rd1),
        .res_ovf(ovf1), .busy(busy1));

    typedef struct {
        logic [3:0][31:0]   p;
        logic signed [63:0] exp_data;
        logic               exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input int sel);
        case (sel)
            0: return pr4;
            1: return prs;
            default: return pr1;
        endcase
    endfunction

    // Present one product and wait (bounded) for it to be accepted.
    task automatic push(input int sel, input logic [31:0] v);
        int t = 0;
        prod_valid = 1'b1;
        prod_data  = v;
        while (!rdy(sel) && t < 50) begin
            step();
            t++;
        end
        if (!rdy(sel)) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: prod_ready stayed 0, expected 1");
        end
        step();
        prod_valid = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    vec_t tbl[4];

    initial begin
        rst = 1'b1; flush = 1'b0; prod_valid = 1'b0; prod_data = '0; res_ready = 1'b0;

        tbl[0].p = {32'd4, 32'd3, 32'd2, 32'd1};
        tbl[0].exp_data = 64'sd10;          tbl[0].exp_ovf = 1'b0;
        tbl[1].p = {32'hC0000000, 32'd500, 32'hFFFFFC18, 32'hFFFFFFFF};
        tbl[1].exp_data = -64'sd1073742325; tbl[1].exp_ovf = 1'b0;
        tbl[2].p = {4{32'h7FFFFFFF}};
        tbl[2].exp_data = 64'sd8589934588;  tbl[2].exp_ovf = 1'b0;
        tbl[3].p = {4{32'h80000000}};
        tbl[3].exp_data = -64'sd8589934592; tbl[3].exp_ovf = 1'b0;

        do_reset();
        chk("reset_res_valid", 64'(rv4), 64'd0);
        chk("reset_res_data", $signed(rd4), 64'sd0);
        chk("reset_res_ovf", 64'(ovf4), 64'd0);
        chk("reset_prod_ready", 64'(pr4), 64'd1);
        chk("reset_busy", 64'(busy4), 64'd0);

        // Table vectors through the VEC_LEN=4 instance.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) push(0, tbl[i].p[k]);
            chk($sformatf("v%0d_res_valid", i), 64'(rv4), 64'd1);
            chk($sformatf("v%0d_res_data", i), $signed(rd4), tbl[i].exp_data);
            chk($sformatf("v%0d_res_ovf", i), 64'(ovf4), 64'(tbl[i].exp_ovf));
            chk($sformatf("v%0d_ready_held", i), 64'(pr4), 64'd0);
            drain();
            chk($sformatf("v%0d_drained", i), 64'(rv4), 64'd0);
        end

        // Backpressure: result held five cycles with a product waiting.
        for (int k = 1; k <= 4; k++) push(0, 32'(k));
        prod_valid = 1'b1; prod_data = 32'd99;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_res_valid", 64'(rv4), 64'd1);
            chk("bp_res_data", $signed(rd4), 64'sd10);
            chk("bp_prod_ready", 64'(pr4), 64'd0);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_valid_drop", 64'(rv4), 64'd0);
        chk("bp_ready_back", 64'(pr4), 64'd1);
        chk("bp_not_yet_busy", 64'(busy4), 64'd0);
        step();
        prod_valid = 1'b0;
        chk("bp_next_accept", 64'(busy4), 64'd1);

        // Flush mid-vector, with a product presented in the same cycle.
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_clear_busy", 64'(busy4), 64'd0);
        push(0, 32'd7); push(0, 32'd9);
        flush = 1'b1; prod_valid = 1'b1; prod_data = 32'd100;
        step();
        flush = 1'b0; prod_valid = 1'b0;
        chk("flush_busy", 64'(busy4), 64'd0);
        for (int k = 0; k < 4; k++) push(0, 32'd1);
        chk("flush_res_valid", 64'(rv4), 64'd1);
        chk("flush_res_data", $signed(rd4), 64'sd4);
        drain();

        // Reset mid-vector behaves the same.
        push(0, 32'd7); push(0, 32'd9);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_mid_busy", 64'(busy4), 64'd0);
        chk("rst_mid_valid", 64'(rv4), 64'd0);
        for (int k = 0; k < 4; k++) push(0, 32'd1);
        chk("rst_res_data", $signed(rd4), 64'sd4);

        // Flush drops a held result.
        flush = 1'b1; step(); flush = 1'b0;
        chk("flush_hold_valid", 64'(rv4), 64'd0);
        chk("flush_hold_ready", 64'(pr4), 64'd1);

        // Saturation versus wrap, ACC_W=34, sixteen products of 2^30.
        do_reset();
        for (int k = 0; k < 16; k++) push(1, 32'h40000000);
        chk("sat_valid", 64'(rvs), 64'd1);
        chk("sat_data", $signed(rds), 64'sh1FFFFFFFF);
        chk("sat_ovf", 64'(ovfs), 64'd1);
        chk("wrap_valid", 64'(rvw), 64'd1);
        chk("wrap_data", $signed(rdw), 64'sd0);
        chk("wrap_ovf", 64'(ovfw), 64'd1);

        // VEC_LEN=1: back-to-back products with res_ready held high.
        do_reset();
        res_ready = 1'b1; prod_valid = 1'b1; prod_data = 32'd5;
        step();
        chk("v1_first_valid", 64'(rv1), 64'd1);
        chk("v1_first_data", $signed(rd1), 64'sd5);
        chk("v1_bubble_ready", 64'(pr1), 64'd0);
        prod_data = 32'hFFFFFFFD;
        step();
        chk("v1_gap_valid", 64'(rv1), 64'd0);
        chk("v1_gap_ready", 64'(pr1), 64'd1);
        step();
        prod_valid = 1'b0; res_ready = 1'b0;
        chk("v1_second_valid", 64'(rv1), 64'd1);
        chk("v1_second_data", $signed(rd1), -64'sd3);
        chk("v1_second_ovf", 64'(ovf1), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
